// File: rtl/fixed_rr_pkg.sv
// Shared constants, Q-format widths and FSM state encoding for the
// exponential argument-reduction stage (fixed_range_reduce).
package fixed_rr_pkg;

  localparam int unsigned FRAC_W = 28;  // fractional bits of Q formats
  localparam int unsigned XF_W   = 36;  // signed Q8.28 operand
  localparam int unsigned P_W    = 68;  // signed Q10.56 product
  localparam int unsigned RR_W   = 40;  // residual working width
  localparam int unsigned K_W    = 12;  // working width of k before trim

  localparam logic [31:0] LN2     = 32'h0B17_217F;  // Q0.28
  localparam logic [31:0] INV_LN2 = 32'h1715_4765;  // Q2.28
  localparam logic [31:0] OVF_THR = 32'h42B1_7218;  // |x| bits, sign 0
  localparam logic [31:0] UNF_THR = 32'h42AE_AC50;  // |x| bits, sign 1

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    KEST,
    RESID,
    DONE
  } state_t;

endpackage

// File: rtl/fixed_rr_align.sv
// Combinational float -> signed Q8.28 aligner. Truncates toward zero;
// exponent 0 (zero/denormal) yields zero. Results for magnitudes above the
// Q8.28 range are meaningless; the caller classifies those separately.
// Ports: sign, exp_f[7:0], man[22:0] in; xf[35:0] (signed), zero out.
module fixed_rr_align
  import fixed_rr_pkg::*;
(
  input  logic                   sign,
  input  logic [7:0]             exp_f,
  input  logic [22:0]            man,
  output logic signed [XF_W-1:0] xf,
  output logic                   zero
);

  logic [23:0]     mant;
  logic [XF_W-1:0] mag;
  logic [7:0]      rsh;

  // 1.m * 2^(e-127) in Q.28 is mant24 shifted left by (e - 122)
  always_comb begin
    mant = {1'b1, man};
    mag  = '0;
    rsh  = '0;
    zero = (exp_f == 8'd0);
    if (!zero) begin
      if (exp_f >= 8'd122) begin
        if (exp_f <= 8'd133) begin
          mag = XF_W'(mant) << (exp_f - 8'd122);
        end
      end else begin
        rsh = 8'd122 - exp_f;
        if (rsh < 8'd24) begin
          mag = XF_W'(mant >> rsh);
        end
      end
    end
    xf = sign ? -$signed(mag) : $signed(mag);
  end

endmodule

// File: rtl/fixed_range_reduce.sv
// Argument reduction x = k*ln2 + r for the fixed-point exp datapath.
// Optional macro FIXED_RR_NAN_EN: classify NaN operands on the nan port;
// when undefined nan is tied 0 and NaN falls into ovf/unf by magnitude.
// Ports: ck2/res (sync active-high), in_valid/in_ready/num operand
// handshake, out_valid/out_ready result handshake, r (Q3.28, sign 0),
// k (signed 8-bit), ovf/unf/nan class flags.
module fixed_range_reduce
  import fixed_rr_pkg::*;
(
  input  logic        ck2,
  input  logic        res,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] num,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] r,
  output logic [7:0]  k,
  output logic        ovf,
  output logic        unf,
  output logic        nan
);

  state_t                   state;
  logic [31:0]              num_q;
  logic signed [XF_W-1:0]   xf_q;
  logic signed [K_W-1:0]    k_est;

  logic signed [XF_W-1:0]   align_xf;
  logic                     align_zero;
  logic signed [P_W-1:0]    p_c;
  logic signed [K_W-1:0]    k_est_c;
  logic signed [RR_W-1:0]   xf_ext, ln2_s, k_ext, rr_raw, rr_fix;
  logic signed [K_W-1:0]    k_fix;
  logic                     ovf_c, unf_c;

  fixed_rr_align u_align (
    .sign  (num_q[31]),
    .exp_f (num_q[30:23]),
    .man   (num_q[22:0]),
    .xf    (align_xf),
    .zero  (align_zero)
  );

  // Range classification on raw magnitude bits
  assign ovf_c = !num_q[31] && (num_q[30:0] > 31'(OVF_THR));
  assign unf_c =  num_q[31] && (num_q[30:0] > 31'(UNF_THR));

`ifdef FIXED_RR_NAN_EN
  logic nan_c;
  assign nan_c = (num_q[30:23] == 8'hFF) && (num_q[22:0] != 23'd0);
`else
  assign nan = 1'b0;
`endif

  // k estimate: floor(xf * 1/ln2) via arithmetic shift of the Q10.56 product
  always_comb begin
    p_c     = P_W'(xf_q) * P_W'($signed(INV_LN2));
    k_est_c = K_W'(p_c >>> 56);
  end

  // Residual with a single +/-ln2 correction for the truncated 1/ln2
  always_comb begin
    xf_ext = RR_W'(xf_q);
    ln2_s  = RR_W'(LN2);
    k_ext  = RR_W'(k_est);
    rr_raw = xf_ext - k_ext * ln2_s;
    rr_fix = rr_raw;
    k_fix  = k_est;
    if (rr_raw < 0) begin
      rr_fix = rr_raw + ln2_s;
      k_fix  = k_est - K_W'(1);
    end else if (rr_raw >= ln2_s) begin
      rr_fix = rr_raw - ln2_s;
      k_fix  = k_est + K_W'(1);
    end
  end

  // Control FSM; result registers update only on the edge entering DONE
  always_ff @(posedge ck2) begin
    if (res) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      r         <= '0;
      k         <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
`ifdef FIXED_RR_NAN_EN
      nan       <= 1'b0;
`endif
      num_q     <= '0;
      xf_q      <= '0;
      k_est     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            num_q    <= num;
            in_ready <= 1'b0;
            state    <= CONV;
          end
        end
        CONV: begin
          xf_q  <= align_zero ? '0 : align_xf;
          state <= KEST;
`ifdef FIXED_RR_NAN_EN
          if (nan_c) begin
            {ovf, unf, nan} <= 3'b001;
            k         <= 8'h00;
            r         <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else
`endif
          if (ovf_c) begin
            ovf       <= 1'b1;
            unf       <= 1'b0;
`ifdef FIXED_RR_NAN_EN
            nan       <= 1'b0;
`endif
            k         <= 8'h7F;
            r         <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (unf_c) begin
            ovf       <= 1'b0;
            unf       <= 1'b1;
`ifdef FIXED_RR_NAN_EN
            nan       <= 1'b0;
`endif
            k         <= 8'h80;
            r         <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        KEST: begin
          k_est <= k_est_c;
          state <= RESID;
        end
        RESID: begin
          r         <= {1'b0, 31'(rr_fix)};
          k         <= 8'(k_fix);
          ovf       <= 1'b0;
          unf       <= 1'b0;
`ifdef FIXED_RR_NAN_EN
          nan       <= 1'b0;
`endif
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_range_reduce.sv
// Scoreboard bench for fixed_range_reduce: the driver pushes hand-computed
// expected results, a monitor pops and compares on each output handshake.
module tb_fixed_range_reduce;

  logic        ck2 = 1'b0;
  logic        res, in_valid, in_ready, out_valid, out_ready;
  logic        ovf, unf, nan;
  logic [31:0] num, r;
  logic [7:0]  k;

  typedef struct packed {
    logic [31:0] r;
    logic [7:0]  k;
    logic        ovf;
    logic        unf;
    logic        nan;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 ck2 = ~ck2;

  fixed_range_reduce dut (
    .ck2       (ck2),
    .res       (res),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .k         (k),
    .ovf       (ovf),
    .unf       (unf),
    .nan       (nan)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rv, input logic [7:0] kv,
                              input logic o, input logic u, input logic n);
    exp_t e;
    e.r = rv; e.k = kv; e.ovf = o; e.unf = u; e.nan = n;
    return e;
  endfunction

  // Monitor: compare on every output handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge ck2);
      if (!res && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("r",   r,         e.r);
          check("k",   32'(k),    32'(e.k));
          check("ovf", 32'(ovf),  32'(e.ovf));
          check("unf", 32'(unf),  32'(e.unf));
          check("nan", 32'(nan),  32'(e.nan));
        end
      end
    end
  end

  // Present an operand and return on the negedge after its capture edge
  task automatic send(input logic [31:0] v, input logic push, input exp_t e);
    @(negedge ck2);
    num      = v;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge ck2);
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (push) sb.push_back(e);
    @(posedge ck2);
    @(negedge ck2);
    in_valid = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 200 && (sb.size() != 0 || !in_ready); i++)
      @(negedge ck2);
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  localparam int NV = 16;
  logic [31:0] vec_num [NV];
  exp_t        vec_exp [NV];

  initial begin
    int   lat;
    logic seen;

    vec_num[0]  = 32'hBF80_0000; vec_exp[0]  = mk(32'h062E_42FE, 8'hFE, 0, 0, 0);
    vec_num[1]  = 32'h0000_0000; vec_exp[1]  = mk(32'h0, 8'h00, 0, 0, 0);
    vec_num[2]  = 32'h0000_0001; vec_exp[2]  = mk(32'h0, 8'h00, 0, 0, 0);
    vec_num[3]  = 32'h8000_0000; vec_exp[3]  = mk(32'h0, 8'h00, 0, 0, 0);
    vec_num[4]  = 32'h42C8_0000; vec_exp[4]  = mk(32'h0, 8'h7F, 1, 0, 0);
    vec_num[5]  = 32'hC2C8_0000; vec_exp[5]  = mk(32'h0, 8'h80, 0, 1, 0);
    vec_num[6]  = 32'h4000_0000; vec_exp[6]  = mk(32'h09D1_BD02, 8'h02, 0, 0, 0);
    vec_num[7]  = 32'h3F00_0000; vec_exp[7]  = mk(32'h0800_0000, 8'h00, 0, 0, 0);
    vec_num[8]  = 32'hBF00_0000; vec_exp[8]  = mk(32'h0317_217F, 8'hFF, 0, 0, 0);
    vec_num[9]  = 32'h42B0_0000; vec_exp[9]  = mk(32'h0A9D_837E, 8'h7E, 0, 0, 0);
    vec_num[10] = 32'h42B1_7219; vec_exp[10] = mk(32'h0, 8'h7F, 1, 0, 0);
    vec_num[11] = 32'hC2AE_AC51; vec_exp[11] = mk(32'h0, 8'h80, 0, 1, 0);
    vec_num[12] = 32'h3380_0000; vec_exp[12] = mk(32'h0000_0010, 8'h00, 0, 0, 0);
    vec_num[13] = 32'hB380_0000; vec_exp[13] = mk(32'h0B17_216F, 8'hFF, 0, 0, 0);
    vec_num[14] = 32'hFF80_0000; vec_exp[14] = mk(32'h0, 8'h80, 0, 1, 0);
`ifdef FIXED_RR_NAN_EN
    vec_num[15] = 32'h7FC0_0000; vec_exp[15] = mk(32'h0, 8'h00, 0, 0, 1);
`else
    vec_num[15] = 32'h7FC0_0000; vec_exp[15] = mk(32'h0, 8'h7F, 1, 0, 0);
`endif

    res = 1'b1; in_valid = 1'b0; num = '0; out_ready = 1'b1;
    repeat (3) @(negedge ck2);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_r",         r,              32'd0);
    check("rst_k",         32'(k),         32'd0);
    check("rst_flags",     32'({ovf, unf, nan}), 32'd0);
    res = 1'b0;

    // 1.0 with latency: out_valid visible in the 4th cycle after capture
    send(32'h3F80_0000, 1'b1, mk(32'h04E8_DE81, 8'h01, 0, 0, 0));
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge ck2);
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    drain();

    for (int i = 0; i < NV; i++) send(vec_num[i], 1'b1, vec_exp[i]);
    drain();

    // Backpressure: DONE holds outputs stable with in_ready low
    @(posedge ck2); #1 out_ready = 1'b0;
    send(32'h4000_0000, 1'b1, mk(32'h09D1_BD02, 8'h02, 0, 0, 0));
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge ck2);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready),  32'd0);
      check("hold_r",     r,              32'h09D1_BD02);
      check("hold_k",     32'(k),         32'h02);
      @(negedge ck2);
    end
    @(posedge ck2); #1 out_ready = 1'b1;
    drain();

    // Reset during KEST discards the operand
    send(32'h3F80_0000, 1'b0, mk(32'h0, 8'h00, 0, 0, 0));
    @(negedge ck2);
    res = 1'b1;
    @(negedge ck2);
    res = 1'b0;
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_k",         32'(k),         32'd0);
    check("mid_rst_r",         r,              32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ck2);
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_valid", 32'(seen), 32'd0);

    // Recovery after the aborted operand
    send(32'hBF00_0000, 1'b1, mk(32'h0317_217F, 8'hFF, 0, 0, 0));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
